// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART receive and transmit cores.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Parity bit that makes the total number of ones odd or even for the given data XOR.
  function automatic logic expected_parity(parity_e mode, logic data_xor);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick generator: a down-counter reloaded from div_i, pulsing tick_o at terminal count.
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || (cnt_q == '0)) begin
      cnt_d = div_i;
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  assign tick_o = !clear_i && (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampled UART receiver with majority vote, configurable frame format and a one-entry
// valid/ready holding register.
//   state  | meaning
//   IDLE   | waiting for a falling edge on rx_s
//   START  | validating the start bit at mid-bit
//   DATA   | shifting in data bits LSB first
//   PARITY | checking the parity bit
//   STOP   | checking stop bits; last stop vote delivers the word
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter parity_e     PARITY     = PAR_NONE,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DIV_W-1:0]     baud_div_i,
  input  logic                 uart_rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] SAMP_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SAMP_HI   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SAMP_END  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [SW-1:0]        samp_q, samp_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  logic             rx_s, fall, tick, vote, vote_now, bit_end, last_vote, tick_clear;
  logic [DIV_W-1:0] tick_div;

  assign rx_s       = sync_q[1];
  assign fall       = rx_prev_q & ~rx_s;
  assign tick_clear = (state_q == IDLE);
  // While idle the divisor input tracks the port, so the value at the start edge is what runs.
  assign tick_div   = tick_clear ? baud_div_i : div_q;

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud_tick (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (tick_clear),
    .div_i   (tick_div),
    .tick_o  (tick)
  );

  assign vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign vote_now = tick && (samp_q == SAMP_HI);
  assign bit_end  = tick && (samp_q == SAMP_END);

  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[0], uart_rx_i};
    rx_prev_d    = rx_s;
    div_d        = tick_clear ? baud_div_i : div_q;
    samp_d       = samp_q;
    bit_d        = bit_q;
    smp_d        = smp_q;
    shift_d      = shift_q;
    ferr_acc_d   = ferr_acc_q;
    perr_acc_d   = perr_acc_q;
    data_d       = data_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    valid_d      = valid_q & ~ready_i;
    overrun_d    = 1'b0;
    last_vote    = 1'b0;

    if (tick) begin
      if (samp_q == SAMP_LO)  smp_d[0] = rx_s;
      if (samp_q == SAMP_MID) smp_d[1] = rx_s;
      samp_d = (samp_q == SAMP_END) ? '0 : samp_q + SW'(1);
    end

    case (state_q)
      IDLE: begin
        samp_d     = '0;
        bit_d      = '0;
        ferr_acc_d = 1'b0;
        perr_acc_d = 1'b0;
        if (fall) state_d = START;
      end
      START: begin
        if (vote_now && vote) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (vote_now) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      uart_pkg::PARITY: begin
        if (vote_now) perr_acc_d = (vote != expected_parity(PARITY, ^shift_q));
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (vote_now) begin
          ferr_acc_d = ferr_acc_q | ~vote;
          // Leave at the vote so a start edge half a bit later is still seen.
          if (bit_q == STOP_LAST) begin
            last_vote = 1'b1;
            state_d   = IDLE;
          end
        end else if (bit_end) begin
          bit_d = bit_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (last_vote) begin
      if (!valid_q || ready_i) begin
        valid_d      = 1'b1;
        data_d       = shift_q;
        frame_err_d  = ferr_acc_q | ~vote;
        parity_err_d = perr_acc_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      sync_q       <= 2'b11;
      rx_prev_q    <= 1'b1;
      div_q        <= '0;
      samp_q       <= '0;
      bit_q        <= '0;
      smp_q        <= '0;
      shift_q      <= '0;
      ferr_acc_q   <= 1'b0;
      perr_acc_q   <= 1'b0;
      data_q       <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      rx_prev_q    <= rx_prev_d;
      div_q        <= div_d;
      samp_q       <= samp_d;
      bit_q        <= bit_d;
      smp_q        <= smp_d;
      shift_q      <= shift_d;
      ferr_acc_q   <= ferr_acc_d;
      perr_acc_q   <= perr_acc_d;
      data_q       <= data_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_o       = data_q;
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;
  assign valid_o      = valid_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: 8N1, 8E1 and 7O2 instances on a shared clock and divisor.
module tb_uart_rx_core;

  localparam int BIT_CLKS = 64;

  typedef struct packed {
    logic [8:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  logic        clk, rst;
  logic [15:0] baud_div;
  logic        rx0, rx1, rx2;
  logic        ready0, ready1, ready2;
  logic [7:0]  data0, data1;
  logic [6:0]  data2;
  logic        fe0, fe1, fe2, pe0, pe1, pe2;
  logic        valid0, valid1, valid2;
  logic        ovr0, ovr1, ovr2;
  logic        busy0, busy1, busy2;

  int   n_vec = 0;
  int   n_err = 0;
  int   acc[3];
  int   ovr[3];
  exp_t sb[3][$];

  uart_rx_core #(.DATA_BITS(8), .PARITY(uart_pkg::PAR_NONE), .STOP_BITS(1)) u_rx8n1 (
    .clk_i(clk), .rst_i(rst), .baud_div_i(baud_div), .uart_rx_i(rx0), .data_o(data0),
    .frame_err_o(fe0), .parity_err_o(pe0), .valid_o(valid0), .ready_i(ready0),
    .overrun_o(ovr0), .busy_o(busy0));

  uart_rx_core #(.DATA_BITS(8), .PARITY(uart_pkg::PAR_EVEN), .STOP_BITS(1)) u_rx8e1 (
    .clk_i(clk), .rst_i(rst), .baud_div_i(baud_div), .uart_rx_i(rx1), .data_o(data1),
    .frame_err_o(fe1), .parity_err_o(pe1), .valid_o(valid1), .ready_i(ready1),
    .overrun_o(ovr1), .busy_o(busy1));

  uart_rx_core #(.DATA_BITS(7), .PARITY(uart_pkg::PAR_ODD), .STOP_BITS(2)) u_rx7o2 (
    .clk_i(clk), .rst_i(rst), .baud_div_i(baud_div), .uart_rx_i(rx2), .data_o(data2),
    .frame_err_o(fe2), .parity_err_o(pe2), .valid_o(valid2), .ready_i(ready2),
    .overrun_o(ovr2), .busy_o(busy2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_rx(input int w, input logic v);
    case (w)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic push_exp(input int w, input logic [8:0] d, input logic fe, input logic pe);
    exp_t e;
    e.data = d;
    e.fe   = fe;
    e.pe   = pe;
    sb[w].push_back(e);
  endtask

  // Bits go out LSB first; gmask marks bits that get a one-clock inverted glitch at mid-bit.
  task automatic send_frame(input int w, input logic [11:0] bits, input int n,
                            input logic [11:0] gmask);
    for (int i = 0; i < n; i++) begin
      drive_rx(w, bits[i]);
      if (gmask[i]) begin
        cycles(36);
        drive_rx(w, ~bits[i]);
        cycles(1);
        drive_rx(w, bits[i]);
        cycles(BIT_CLKS - 37);
      end else begin
        cycles(BIT_CLKS);
      end
    end
    drive_rx(w, 1'b1);
    cycles(8);
  endtask

  task automatic mon(input int w, input logic v, input logic r, input logic [8:0] d,
                     input logic fe, input logic pe, input logic ov);
    exp_t e;
    if (rst) return;
    if (ov) ovr[w]++;
    if (v && r) begin
      acc[w]++;
      if (sb[w].size() == 0) begin
        check($sformatf("dut%0d_spurious_word", w), 32'(d), 32'h1ff);
      end else begin
        e = sb[w].pop_front();
        check($sformatf("dut%0d_data", w), 32'(d), 32'(e.data));
        check($sformatf("dut%0d_frame_err", w), 32'(fe), 32'(e.fe));
        check($sformatf("dut%0d_parity_err", w), 32'(pe), 32'(e.pe));
      end
    end
  endtask

  always @(negedge clk) mon(0, valid0, ready0, {1'b0, data0}, fe0, pe0, ovr0);
  always @(negedge clk) mon(1, valid1, ready1, {1'b0, data1}, fe1, pe1, ovr1);
  always @(negedge clk) mon(2, valid2, ready2, {2'b00, data2}, fe2, pe2, ovr2);

  initial begin
    int         a;
    logic       p;
    logic [7:0] b3c;
    logic [6:0] d55;
    for (int i = 0; i < 3; i++) begin
      acc[i] = 0;
      ovr[i] = 0;
    end
    rst = 1'b1;
    baud_div = 16'd3;
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    ready0 = 1'b1; ready1 = 1'b1; ready2 = 1'b1;
    cycles(5);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(valid0), 0);
    check("rst_data", 32'(data0), 0);
    check("rst_frame_err", 32'(fe0), 0);
    check("rst_parity_err", 32'(pe0), 0);
    check("rst_overrun", 32'(ovr0), 0);
    check("rst_busy", 32'(busy0), 0);
    cycles(20);

    // 8N1 0xA5 with ready held high: exactly one accepted word
    a = acc[0];
    push_exp(0, 9'h0A5, 1'b0, 1'b0);
    send_frame(0, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 12'h0);
    cycles(10);
    check("a5_single_accept", 32'(acc[0] - a), 1);

    // 8E1: parity forced 0 on 0x07 (needs 1), then a correct 0x3C
    push_exp(1, 9'h007, 1'b0, 1'b1);
    send_frame(1, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 12'h0);
    p = ^8'h3C;
    push_exp(1, 9'h03C, 1'b0, 1'b0);
    send_frame(1, {1'b0, 1'b1, p, 8'h3C, 1'b0}, 11, 12'h0);

    // 7O2: correct 0x55, then second stop bit low
    d55 = 7'h55;
    p = ~^d55;
    push_exp(2, 9'h055, 1'b0, 1'b0);
    send_frame(2, {2'b11, p, d55, 1'b0}, 11, 12'h0);
    push_exp(2, 9'h055, 1'b1, 1'b0);
    send_frame(2, {2'b01, p, d55, 1'b0}, 11, 12'h0);

    // 8N1 stop bit low, then a break
    push_exp(0, 9'h0A5, 1'b1, 1'b0);
    send_frame(0, {2'b00, 1'b0, 8'hA5, 1'b0}, 10, 12'h0);
    push_exp(0, 9'h000, 1'b1, 1'b0);
    send_frame(0, 12'h000, 10, 12'h0);

    // 20-clock low glitch on idle line is a false start
    a = acc[0];
    rx0 = 1'b0;
    cycles(20);
    rx0 = 1'b1;
    cycles(200);
    check("glitch_no_word", 32'(acc[0] - a), 0);
    check("glitch_idle", 32'(busy0), 0);

    // Overrun: two frames with ready low, only the first survives
    ready0 = 1'b0;
    push_exp(0, 9'h011, 1'b0, 1'b0);
    send_frame(0, {2'b00, 1'b1, 8'h11, 1'b0}, 10, 12'h0);
    send_frame(0, {2'b00, 1'b1, 8'h22, 1'b0}, 10, 12'h0);
    cycles(20);
    check("hold_valid", 32'(valid0), 1);
    check("hold_data", 32'(data0), 32'h11);
    check("overrun_pulses", 32'(ovr[0]), 1);
    ready0 = 1'b1;
    cycles(5);
    check("drained_valid", 32'(valid0), 0);

    // Single-clock glitch at mid-bit of every data bit
    push_exp(0, 9'h0C3, 1'b0, 1'b0);
    send_frame(0, {2'b00, 1'b1, 8'hC3, 1'b0}, 10, 12'h1FE);

    // Reset in the middle of the data bits of 0x3C
    a = acc[0];
    b3c = 8'h3C;
    rx0 = 1'b0;
    cycles(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rx0 = b3c[i];
      cycles(BIT_CLKS);
    end
    rst = 1'b1;
    cycles(3);
    rx0 = 1'b1;
    cycles(2);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy0), 0);
    check("midrst_valid", 32'(valid0), 0);
    cycles(200);
    check("midrst_no_word", 32'(acc[0] - a), 0);
    push_exp(0, 9'h081, 1'b0, 1'b0);
    send_frame(0, {2'b00, 1'b1, 8'h81, 1'b0}, 10, 12'h0);

    // Divisor change mid-frame must not disturb the frame in flight
    push_exp(0, 9'h05A, 1'b0, 1'b0);
    fork
      send_frame(0, {2'b00, 1'b1, 8'h5A, 1'b0}, 10, 12'h0);
      begin
        cycles(200);
        baud_div = 16'd7;
      end
    join
    baud_div = 16'd3;

    for (int i = 0; i < 1000 && (sb[0].size() + sb[1].size() + sb[2].size()) != 0; i++) begin
      cycles(1);
    end
    check("sb_left_8n1", 32'(sb[0].size()), 0);
    check("sb_left_8e1", 32'(sb[1].size()), 0);
    check("sb_left_7o2", 32'(sb[2].size()), 0);
    check("overrun_total_8n1", 32'(ovr[0]), 1);
    check("overrun_total_8e1", 32'(ovr[1]), 0);
    check("overrun_total_7o2", 32'(ovr[2]), 0);
    check("words_8n1", 32'(acc[0]), 7);
    check("words_8e1", 32'(acc[1]), 2);
    check("words_7o2", 32'(acc[2]), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
